bus_arbiter: RTL and testbench

- Two-master arbiter for the shared memory-mapped I/O bus (memAddr, we, re, OR-combined dataBus).
- Master 0 is the CPU. Master 1 is a secondary initiator (DMA/debug port).
- Grants bus ownership round-robin, supports locked multi-cycle sequences with a bounded hold time, and returns registered read data to the issuing master.
- Sits between the masters and the slaves (memory, LEDR/LEDG, HEX, switch, key, timer); its dataBusOut is ORed onto dataBus.

---
 rtl/bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master arbiter for the shared memory-mapped I/O bus. Master 0 is the
// CPU and master 1 is a secondary initiator (DMA/debug). Ownership is granted
// round-robin, with a one-cycle IDLE turnaround between owners. A master can
// hold the bus for a locked multi-cycle sequence. If the other master is
// waiting, that hold is limited to MAX_LOCK cycles. Read data is registered
// and returned to whichever master issued the read.
//
// Ports
//   clk, reset            system clock, asynchronous active-low reset
//   reqN, lockN           request / hold-grant from master N
//   weN, reN              write / read strobes from master N (used only while granted)
//   addrN, wdataN         transfer address / write data from master N
//   gnt0, gnt1            registered grant, one-hot or zero
//   rvalid0, rvalid1      one-cycle read-data-valid pulse to the issuing master
//   rdata                 registered read data, shared by both masters
//   lock_err              one-cycle pulse when a lock is forcibly broken
//   we, re, memAddr       bus strobes and address driven by the current owner
//   dataBusOut            write data onto the OR bus, 0 when not writing
//   dataBusIn             OR-combined data bus (read return)
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int DBITS    = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic             we0,
  input  logic             we1,
  input  logic             re0,
  input  logic             re1,
  input  logic [DBITS-1:0] addr0,
  input  logic [DBITS-1:0] addr1,
  input  logic [DBITS-1:0] wdata0,
  input  logic [DBITS-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [DBITS-1:0] rdata,
  output logic             lock_err,
  output logic             we,
  output logic             re,
  output logic [DBITS-1:0] memAddr,
  output logic [DBITS-1:0] dataBusOut,
  input  logic [DBITS-1:0] dataBusIn
);

  // The extra count bit keeps the width nonzero even when MAX_LOCK is 1.
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               lock_err_q, lock_err_d;
  logic               rvalid0_q, rvalid1_q;
  logic [DBITS-1:0]   rdata_q;

  // Signals of the current owner, plus the other master's request.
  // Everything is zero in IDLE, so the bus is never driven there.
  logic               cur_req, cur_lock, cur_we, cur_re, oth_req;
  logic [DBITS-1:0]   cur_addr, cur_wdata;

  always_comb begin
    cur_req   = 1'b0;
    cur_lock  = 1'b0;
    cur_we    = 1'b0;
    cur_re    = 1'b0;
    oth_req   = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    case (state_q)
      OWN0: begin
        cur_req   = req0;
        cur_lock  = lock0;
        cur_we    = we0;
        cur_re    = re0;
        oth_req   = req1;
        cur_addr  = addr0;
        cur_wdata = wdata0;
      end
      OWN1: begin
        cur_req   = req1;
        cur_lock  = lock1;
        cur_we    = we1;
        cur_re    = re1;
        oth_req   = req0;
        cur_addr  = addr1;
        cur_wdata = wdata1;
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    lock_cnt_d   = lock_cnt_q;
    lock_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        lock_cnt_d = '0;
        if (req0 && req1) state_d = last_owner_q ? OWN0 : OWN1;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!cur_req) begin
          state_d = IDLE;
        end else if (!cur_lock) begin
          // Unlocked: yield after one transfer whenever the other master is waiting.
          if (oth_req) state_d = IDLE;
        end else if (oth_req && (lock_cnt_q == CNT_MAX)) begin
          // The lock has used up its hold budget and the other master is waiting.
          state_d    = IDLE;
          lock_err_d = 1'b1;
        end
        if (state_d == IDLE)
          lock_cnt_d = '0;
        else if (cur_lock && (lock_cnt_q != CNT_MAX))
          lock_cnt_d = lock_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == OWN0) last_owner_d = 1'b0;
    if (state_d == OWN1) last_owner_d = 1'b1;
  end

  // Bus drive is gated by the owner's request. A grant that the master no
  // longer wants therefore issues no strobe.
  always_comb begin
    we         = cur_req & cur_we;
    re         = cur_req & cur_re & ~cur_we;
    memAddr    = cur_addr;
    dataBusOut = we ? cur_wdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      lock_cnt_q   <= '0;
      lock_err_q   <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_err_q   <= lock_err_d;
      // The read is tagged with this cycle's owner. It is still delivered
      // if ownership changes at the same edge.
      rvalid0_q    <= re && (state_q == OWN0);
      rvalid1_q    <= re && (state_q == OWN1);
      if (re) rdata_q <= dataBusIn;
    end
  end

  assign gnt0     = (state_q == OWN0);
  assign gnt1     = (state_q == OWN1);
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;
  assign lock_err = lock_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed testbench for bus_arbiter. It drives a linear sequence of steps
// and checks each step against expected values worked out by hand.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
  localparam int DBITS    = 32;
  localparam int MAX_LOCK = 16;

  logic             clk;
  logic             reset;
  logic             req0, req1, lock0, lock1, we0, we1, re0, re1;
  logic [DBITS-1:0] addr0, addr1, wdata0, wdata1, dataBusIn;
  logic             gnt0, gnt1, rvalid0, rvalid1, lock_err, we, re;
  logic [DBITS-1:0] rdata, memAddr, dataBusOut;

  int tests  = 0;
  int failed = 0;

  bus_arbiter #(.DBITS(DBITS), .MAX_LOCK(MAX_LOCK)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .lock0      (lock0),
    .lock1      (lock1),
    .we0        (we0),
    .we1        (we1),
    .re0        (re0),
    .re1        (re1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata      (rdata),
    .lock_err   (lock_err),
    .we         (we),
    .re         (re),
    .memAddr    (memAddr),
    .dataBusOut (dataBusOut),
    .dataBusIn  (dataBusIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    we0 = 0; we1 = 0; re0 = 0; re1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; dataBusIn = '0;
  endtask

  // Pulse reset between clock edges.
  task automatic pulse_reset();
    reset = 0;
    #2;
    reset = 1;
  endtask

  // Upper bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1;
    #1 reset = 0;
    #2;
    // ---- reset state ----
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_lock_err", 32'(lock_err), 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1;

    // ---- single read by master 0 ----
    req0 = 1; re0 = 1; addr0 = 32'hF000_0014; dataBusIn = 32'h3FF;
    #1;
    chk("t1_idle_re", 32'(re), 32'd0);
    tick();
    chk("t1_gnt0", 32'(gnt0), 32'd1);
    chk("t1_gnt1", 32'(gnt1), 32'd0);
    chk("t1_re", 32'(re), 32'd1);
    chk("t1_memAddr", memAddr, 32'hF000_0014);
    chk("t1_rvalid0_early", 32'(rvalid0), 32'd0);
    tick();
    chk("t1_rvalid0", 32'(rvalid0), 32'd1);
    chk("t1_rdata", rdata, 32'h3FF);
    chk("t1_rvalid1", 32'(rvalid1), 32'd0);
    idle_inputs();
    tick();
    chk("t1_end_gnt0", 32'(gnt0), 32'd0);
    chk("t1_end_rvalid0", 32'(rvalid0), 32'd0);
    chk("t1_rdata_hold", rdata, 32'h3FF);

    // ---- contended, unlocked: alternate 0, IDLE, 1, IDLE, 0 ----
    pulse_reset();
    chk("t2_rst_rdata", rdata, 32'd0);
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    addr0 = 32'h100; addr1 = 32'h200; wdata0 = 32'hA; wdata1 = 32'hB;
    tick();
    chk("t2_c1_gnt0", 32'(gnt0), 32'd1);
    chk("t2_c1_gnt1", 32'(gnt1), 32'd0);
    chk("t2_c1_dbo", dataBusOut, 32'hA);
    chk("t2_c1_addr", memAddr, 32'h100);
    tick();
    chk("t2_c2_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("t2_c2_we", 32'(we), 32'd0);
    chk("t2_c2_dbo", dataBusOut, 32'd0);
    chk("t2_c2_addr", memAddr, 32'd0);
    tick();
    chk("t2_c3_gnt1", 32'(gnt1), 32'd1);
    chk("t2_c3_gnt0", 32'(gnt0), 32'd0);
    chk("t2_c3_dbo", dataBusOut, 32'hB);
    tick();
    chk("t2_c4_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("t2_c4_we", 32'(we), 32'd0);
    tick();
    chk("t2_c5_gnt0", 32'(gnt0), 32'd1);
    idle_inputs();
    tick();
    chk("t2_end_gnt0", 32'(gnt0), 32'd0);

    // ---- master 1 alone: five back-to-back writes ----
    req1 = 1; we1 = 1; addr1 = 32'hF000_0004; wdata1 = 32'd1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      wdata1 = 32'(i);
      #1;
      chk($sformatf("t3_w%0d_gnt1", i), 32'(gnt1), 32'd1);
      chk($sformatf("t3_w%0d_we", i), 32'(we), 32'd1);
      chk($sformatf("t3_w%0d_dbo", i), dataBusOut, 32'(i));
      if (i < 5) tick();
    end
    chk("t3_addr", memAddr, 32'hF000_0004);
    idle_inputs();
    #1;
    chk("t3_we_off", 32'(we), 32'd0);
    tick();
    chk("t3_end_gnt1", 32'(gnt1), 32'd0);

    // ---- locked hold by master 0, broken after MAX_LOCK cycles ----
    req0 = 1; lock0 = 1;
    tick();
    chk("t4_c1_gnt0", 32'(gnt0), 32'd1);
    for (int c = 2; c <= MAX_LOCK; c++) begin
      tick();
      chk($sformatf("t4_c%0d_gnt0", c), 32'(gnt0), 32'd1);
      chk($sformatf("t4_c%0d_lock_err", c), 32'(lock_err), 32'd0);
      if (c == 4) req1 = 1;
    end
    tick();
    chk("t4_brk_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("t4_brk_lock_err", 32'(lock_err), 32'd1);
    tick();
    chk("t4_gnt1", 32'(gnt1), 32'd1);
    chk("t4_lock_err_off", 32'(lock_err), 32'd0);
    idle_inputs();
    tick();
    chk("t4_end_gnt1", 32'(gnt1), 32'd0);

    // ---- write wins over read ----
    req0 = 1; we0 = 1; re0 = 1; addr0 = 32'h40; wdata0 = 32'h55; dataBusIn = 32'h77;
    tick();
    chk("t5_we", 32'(we), 32'd1);
    chk("t5_re", 32'(re), 32'd0);
    chk("t5_dbo", dataBusOut, 32'h55);
    tick();
    chk("t5_rvalid0", 32'(rvalid0), 32'd0);
    chk("t5_rdata", rdata, 32'd0);
    idle_inputs();
    tick();

    // ---- asynchronous reset in the middle of a read ----
    req0 = 1; re0 = 1; addr0 = 32'h80; dataBusIn = 32'h1234;
    tick();
    chk("t6_re_before", 32'(re), 32'd1);
    #2;
    reset = 0;
    #1;
    chk("t6_rst_gnt0", 32'(gnt0), 32'd0);
    chk("t6_rst_re", 32'(re), 32'd0);
    chk("t6_rst_addr", memAddr, 32'd0);
    chk("t6_rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("t6_rst_rdata", rdata, 32'd0);
    req1 = 1;
    tick();
    reset = 1;
    chk("t6_hold_rvalid0", 32'(rvalid0), 32'd0);
    tick();
    chk("t6_first_gnt0", 32'(gnt0), 32'd1);
    chk("t6_first_gnt1", 32'(gnt1), 32'd0);
    chk("t6_post_rvalid0", 32'(rvalid0), 32'd0);

    idle_inputs();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
